// File: rtl/xnor_db_pkg.sv
// xnor_db_pkg: shared defaults and saturation helper for the xnor_db block
package xnor_db_pkg;
  localparam int WIDTH_DEF = 1;
  localparam int CNT_W_DEF = 8;
  function automatic int unsigned sat_val(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/xnor_db_cnt.sv
// xnor_db_cnt: saturating run counter with sticky saturation flag
module xnor_db_cnt
  import xnor_db_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             zero,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(sat_val(CNT_W));
  logic [CNT_W-1:0] w_nxt;
  always_comb w_nxt = zero ? '0 : (inc && cnt != MAX) ? cnt + CNT_W'(1'b1) : cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= w_nxt;
      sat <= sat | (w_nxt == MAX);
    end
endmodule

// File: rtl/xnor_db.sv
// xnor_db: bitwise XNOR with registered copy, equality flag, rise pulse
// and a saturating count of consecutive equal cycles
module xnor_db
  import xnor_db_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             clr,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_q,
  output logic             match,
  output logic             match_rise,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);
  logic             w_all;
  logic [WIDTH-1:0] r_z_q;
  logic             r_match;
  logic             r_match_rise;
  assign z          = ~(x ^ y);
  assign w_all      = &z;
  assign z_q        = r_z_q;
  assign match      = r_match;
  assign match_rise = r_match_rise;
  // match keeps tracking through clr; only the pulse is suppressed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_z_q        <= '0;
      r_match      <= 1'b0;
      r_match_rise <= 1'b0;
    end else begin
      r_z_q        <= z;
      r_match      <= w_all;
      r_match_rise <= ~clr & w_all & ~r_match;
    end
  xnor_db_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_all),
    .zero(~w_all),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );
endmodule

// File: tb/tb_xnor_db.sv
// tb_xnor_db: directed checks of xnor_db at WIDTH=1/CNT_W=3 and WIDTH=4
module tb_xnor_db;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       x1 = 1'b0, y1 = 1'b0;
  logic       z1, zq1, m1, r1, s1;
  logic [2:0] c1;
  logic [3:0] x4 = 4'h0, y4 = 4'h0;
  logic [3:0] z4, zq4;
  logic       m4, r4, s4;
  logic [7:0] c4;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xnor_db #(.WIDTH(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .x(x1), .y(y1), .clr(clr),
    .z(z1), .z_q(zq1), .match(m1), .match_rise(r1),
    .match_cnt(c1), .cnt_sat(s1)
  );

  xnor_db #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .x(x4), .y(y4), .clr(clr),
    .z(z4), .z_q(zq4), .match(m4), .match_rise(r4),
    .match_cnt(c4), .cnt_sat(s4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] tt [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       tz [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    #1;
    chk("rst_zq", zq1, 0);
    chk("rst_match", m1, 0);
    chk("rst_rise", r1, 0);
    chk("rst_cnt", c1, 0);
    chk("rst_sat", s1, 0);
    for (int i = 0; i < 4; i++) begin
      {x1, y1} = tt[i];
      #10;
      chk($sformatf("tt_%0d", i), z1, tz[i]);
    end
    @(negedge clk);
    rst = 1'b0;
    x1 = 1'b1; y1 = 1'b1;
    edge_sample();
    chk("lat_zq1", zq1, 1);
    chk("lat_m1", m1, 1);
    chk("lat_rise1", r1, 1);
    @(negedge clk);
    x1 = 1'b0;
    edge_sample();
    chk("lat_zq0", zq1, 0);
    chk("lat_m0", m1, 0);
    chk("lat_rise0", r1, 0);
    chk("lat_cnt0", c1, 0);
    @(negedge clk);
    x1 = 1'b1; y1 = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      edge_sample();
      chk($sformatf("sat_cnt_%0d", i), c1, (i < 7) ? i : 7);
      chk($sformatf("sat_flag_%0d", i), s1, (i >= 7) ? 1 : 0);
      chk($sformatf("sat_rise_%0d", i), r1, (i == 1) ? 1 : 0);
    end
    @(negedge clk);
    x1 = 1'b0;
    edge_sample();
    chk("sat_break_cnt", c1, 0);
    chk("sat_break_flag", s1, 1);
    chk("sat_break_m", m1, 0);
    @(negedge clk);
    x1 = 1'b1;
    repeat (4) edge_sample();
    chk("clr_pre_cnt", c1, 4);
    chk("clr_pre_sat", s1, 1);
    @(negedge clk);
    clr = 1'b1;
    edge_sample();
    chk("clr_cnt", c1, 0);
    chk("clr_sat", s1, 0);
    chk("clr_match", m1, 1);
    chk("clr_zq", zq1, 1);
    @(negedge clk);
    clr = 1'b0;
    x1 = 1'b0;
    edge_sample();
    chk("clr_gap_m", m1, 0);
    @(negedge clk);
    x1 = 1'b1;
    clr = 1'b1;
    edge_sample();
    chk("clr_rise_blk", r1, 0);
    chk("clr_rise_m", m1, 1);
    @(negedge clk);
    clr = 1'b0;
    repeat (5) edge_sample();
    chk("ar_pre_cnt", c1, 5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_zq", zq1, 0);
    chk("ar_match", m1, 0);
    chk("ar_rise", r1, 0);
    chk("ar_cnt", c1, 0);
    chk("ar_sat", s1, 0);
    chk("ar_z", z1, 1);
    @(negedge clk);
    rst = 1'b0;
    edge_sample();
    chk("ar_post_cnt", c1, 1);
    chk("ar_post_rise", r1, 1);
    @(negedge clk);
    x4 = 4'b1010; y4 = 4'b1000;
    #1;
    chk("w4_z", z4, 4'b1101);
    edge_sample();
    chk("w4_match", m4, 0);
    chk("w4_zq", zq4, 4'b1101);
    @(negedge clk);
    y4 = 4'b1010;
    #1;
    chk("w4_z_eq", z4, 4'b1111);
    edge_sample();
    chk("w4_match_eq", m4, 1);
    chk("w4_cnt_eq", c4, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/xnor_db.md
XNOR_DB -- requirements
Module: xnor_db

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1, giving the operand width in bits.
REQ-002 The module SHALL have parameter CNT_W, default 8, giving the match-counter width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port x, input, WIDTH bits: operand A.
REQ-006 The module SHALL have port y, input, WIDTH bits: operand B.
REQ-007 The module SHALL have port clr, input, 1 bit: synchronous clear of the counter and flags.
REQ-008 The module SHALL have port z, output, WIDTH bits: combinational bitwise XNOR of x and y.
REQ-009 The module SHALL have port z_q, output, WIDTH bits: registered copy of z.
REQ-010 The module SHALL have port match, output, 1 bit: registered all-bits-equal flag.
REQ-011 The module SHALL have port match_rise, output, 1 bit: one-cycle pulse on a rising edge of match.
REQ-012 The module SHALL have port match_cnt, output, CNT_W bits: count of consecutive matching cycles.
REQ-013 The module SHALL have port cnt_sat, output, 1 bit: sticky flag set when match_cnt has saturated.

Function
REQ-014 z SHALL equal ~(x ^ y) per bit, purely combinational, independent of clk, rst and clr.
REQ-015 For WIDTH=1, z SHALL follow the truth table 00->1, 01->0, 10->0, 11->1 with zero-cycle latency.
REQ-016 z_q SHALL load z on every rising clk edge, giving one-cycle latency; clr SHALL NOT affect z_q.
REQ-017 match SHALL load the AND-reduction of z each cycle, i.e. 1 exactly when x == y, with one-cycle latency.
REQ-018 match_rise SHALL be 1 for exactly one cycle when match goes 0->1; it SHALL be registered and aligned with that match transition.
REQ-019 match_cnt SHALL increment each cycle in which &z = 1, SHALL reset to 0 in a cycle where &z = 0, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-020 cnt_sat SHALL set on the edge at which match_cnt reaches 2^CNT_W-1, and SHALL remain set until clr or rst.
REQ-021 When clr=1 on an edge, match_cnt, match_rise and cnt_sat SHALL clear; clr SHALL take priority over a simultaneous match.
REQ-022 During clr, match SHALL continue to update normally.
REQ-023 x and y SHALL be sampled only at clk edges for the registered outputs; no X-propagation masking is required.

Reset
REQ-024 While rst=1, z_q, match, match_rise, match_cnt and cnt_sat SHALL be 0 immediately, without waiting for a clock edge.
REQ-025 z SHALL remain a valid combinational output during reset.
REQ-026 After rst deasserts, the first rising edge SHALL update the registers normally; reset asserted mid-count SHALL discard the count.

Structure
REQ-027 The shared package xnor_db_pkg SHALL hold the WIDTH and CNT_W defaults and a function returning the saturation value for a given width.
REQ-028 The saturating counter and sticky flag SHALL be one sub-module, xnor_db_cnt, with ports clk, rst, clr, inc and zero, and outputs cnt and sat.
REQ-029 The combinational XNOR and the match/edge registers SHALL reside in xnor_db.

Verification
REQ-030 Truth table, WIDTH=1, steps 10 ns apart: x,y = 00,01,10,11 -> z = 1,0,0,1 with no clock dependency.
REQ-031 Latency: x=1, y=1 applied before edge N -> z_q=1 and match=1 after edge N; x=0 before edge N+1 -> z_q=0, match=0, match_rise pulses only after edge N.
REQ-032 Saturation, CNT_W=3: hold x=y for 9 cycles -> match_cnt reads 1..7 then holds at 7, cnt_sat=1 from the 7th edge; then set x!=y -> match_cnt=0 and cnt_sat stays 1.
REQ-033 clr priority: clr=1 with x=y while match_cnt=4 -> match_cnt=0, cnt_sat=0, match=1 on that edge.
REQ-034 Async reset: rst pulsed between edges while match_cnt=5 -> all registered outputs 0 immediately, z unchanged.
REQ-035 WIDTH=4: x=4'b1010, y=4'b1000 -> z=4'b1101, match=0 after the next edge.
